// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of the ALU+shifter: queues {A,B,S,Cin,H} commands, issues one
// at a time, waits the ALU result latency and returns O/Cout with a 2-bit sequence tag.
module alu_op_sequencer #(
    parameter int DEPTH      = 4,
    parameter int RESULT_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_s,
    input  logic       cmd_cin,
    input  logic [1:0] cmd_h,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    output logic       alu_cin,
    output logic [1:0] alu_h,
    input  logic [3:0] alu_o,
    input  logic       alu_cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_o,
    output logic       res_cout,
    output logic [1:0] res_tag,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] s;
        logic       cin;
        logic [1:0] h;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    cmd_t          alu_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic [2:0]    lat_cnt;
    logic [1:0]    tag;
    state_t        state;
    state_t        next_state;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // NOTE: the command storage has no reset; count decides which entries are live, so
    // stale contents after reset are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, s: cmd_s, cin: cmd_cin, h: cmd_h};
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values, regardless of
    // the order of statements or processes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (!empty)          next_state = ST_WAIT;
            ST_WAIT: if (lat_cnt == 3'd1) next_state = ST_DONE;
            ST_DONE: if (res_ready)       next_state = ST_IDLE;
            default:                      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = !full;
        push      = cmd_valid && !full;
        pop       = (state == ST_IDLE) && !empty;
        capture   = (state == ST_WAIT) && (lat_cnt == 3'd1);
        res_valid = (state == ST_DONE);
        busy      = !empty || (state != ST_IDLE);
    end

    // Operand registers change only on issue, so the ALU sees stable inputs between ops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q    <= '0;
            lat_cnt  <= '0;
            res_o    <= '0;
            res_cout <= 1'b0;
            res_tag  <= '0;
            tag      <= '0;
        end else begin
            if (pop) begin
                alu_q   <= head;
                lat_cnt <= 3'(RESULT_LAT);
            end else if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (capture) begin
                res_o    <= alu_o;
                res_cout <= alu_cout;
                res_tag  <= tag;
                tag      <= tag + 2'd1;
            end
        end
    end

    assign alu_a   = alu_q.a;
    assign alu_b   = alu_q.b;
    assign alu_s   = alu_q.s;
    assign alu_cin = alu_q.cin;
    assign alu_h   = alu_q.h;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a queue-based reference model drives the
// RESULT_LAT=1 instance; a RESULT_LAT=3 instance covers latency and mid-operation reset.
module tb_alu_op_sequencer;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] s;
        logic       cin;
        logic [1:0] h;
    } cmd_t;

    logic clk;
    logic reset;

    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_s;
    logic       cmd_cin;
    logic [1:0] cmd_h;
    logic [3:0] alu_a, alu_b, alu_o;
    logic [2:0] alu_s;
    logic       alu_cin, alu_cout;
    logic [1:0] alu_h;
    logic       res_valid, res_ready, res_cout, busy;
    logic [3:0] res_o;
    logic [1:0] res_tag;

    logic       l3_cmd_valid, l3_cmd_ready;
    logic [3:0] l3_cmd_a, l3_cmd_b;
    logic [2:0] l3_cmd_s;
    logic       l3_cmd_cin;
    logic [1:0] l3_cmd_h;
    logic [3:0] l3_alu_a, l3_alu_b, l3_alu_o;
    logic [2:0] l3_alu_s;
    logic       l3_alu_cin, l3_alu_cout;
    logic [1:0] l3_alu_h;
    logic       l3_res_valid, l3_res_ready, l3_res_cout, l3_busy;
    logic [3:0] l3_res_o;
    logic [1:0] l3_res_tag;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH), .RESULT_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_cin(cmd_cin), .cmd_h(cmd_h),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin), .alu_h(alu_h),
        .alu_o(alu_o), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_o(res_o), .res_cout(res_cout), .res_tag(res_tag), .busy(busy)
    );

    // Latency-1 ALU stub: result settles within the issue cycle.
    assign alu_o    = alu_a ^ alu_b;
    assign alu_cout = alu_cin;

    alu_op_sequencer #(.DEPTH(DEPTH), .RESULT_LAT(3)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready),
        .cmd_a(l3_cmd_a), .cmd_b(l3_cmd_b), .cmd_s(l3_cmd_s), .cmd_cin(l3_cmd_cin),
        .cmd_h(l3_cmd_h),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_s(l3_alu_s), .alu_cin(l3_alu_cin),
        .alu_h(l3_alu_h), .alu_o(l3_alu_o), .alu_cout(l3_alu_cout),
        .res_valid(l3_res_valid), .res_ready(l3_res_ready),
        .res_o(l3_res_o), .res_cout(l3_res_cout), .res_tag(l3_res_tag), .busy(l3_busy)
    );

    // Latency-3 ALU stub: two register stages, so stale results are visible before settling.
    logic [3:0] l3_d1, l3_d2;
    logic       l3_c1, l3_c2;
    always @(posedge clk) begin
        l3_d1 <= l3_alu_a ^ l3_alu_b;
        l3_d2 <= l3_d1;
        l3_c1 <= l3_alu_cin;
        l3_c2 <= l3_c1;
    end
    assign l3_alu_o    = l3_d2;
    assign l3_alu_cout = l3_c2;

    // Reference model: command queue plus one in-flight op and one held result.
    cmd_t       q[$];
    bit         m_inflight;
    int         m_phase;
    cmd_t       m_cur;
    cmd_t       m_alu;
    bit         m_rv;
    logic [3:0] m_o;
    logic       m_cout;
    logic [1:0] m_rtag;
    int         m_tag;

    logic [3:0] got_o[$];
    logic [1:0] got_tag[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_inflight = 1'b0;
        m_phase    = 0;
        m_cur      = '0;
        m_alu      = '0;
        m_rv       = 1'b0;
        m_o        = '0;
        m_cout     = 1'b0;
        m_rtag     = '0;
        m_tag      = 0;
    endfunction

    function automatic void model_edge();
        bit   push_ok;
        cmd_t c;
        push_ok = cmd_valid && (q.size() < DEPTH);
        c = '{a: cmd_a, b: cmd_b, s: cmd_s, cin: cmd_cin, h: cmd_h};
        if (m_inflight) begin
            m_phase++;
            if (m_phase == LAT) begin
                m_o        = m_cur.a ^ m_cur.b;
                m_cout     = m_cur.cin;
                m_rtag     = 2'(m_tag);
                m_tag      = (m_tag + 1) % 4;
                m_rv       = 1'b1;
                m_inflight = 1'b0;
            end
        end else if (m_rv) begin
            if (res_ready) m_rv = 1'b0;
        end else if (q.size() > 0) begin
            m_cur      = q.pop_front();
            m_alu      = m_cur;
            m_inflight = 1'b1;
            m_phase    = 0;
        end
        if (push_ok) q.push_back(c);
    endfunction

    task automatic compare();
        check("cmd_ready", cmd_ready, q.size() < DEPTH);
        check("busy", busy, (q.size() != 0) || m_inflight || m_rv);
        check("alu_bus", {alu_a, alu_b, alu_s, alu_cin, alu_h}, m_alu);
        check("result", {res_valid, res_o, res_cout, res_tag}, {m_rv, m_o, m_cout, m_rtag});
    endtask

    task automatic drive(input bit v, input cmd_t c);
        cmd_valid = v;
        {cmd_a, cmd_b, cmd_s, cmd_cin, cmd_h} = c;
    endtask

    function automatic cmd_t rand_cmd();
        logic [13:0] r;
        r = 14'($urandom);
        return r;
    endfunction

    task automatic step();
        if (res_valid && res_ready) begin
            got_o.push_back(res_o);
            got_tag.push_back(res_tag);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        res_ready    = 1'b0;
        l3_cmd_valid = 1'b0;
        l3_res_ready = 1'b0;
        model_reset();
        #1;
        compare();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   acc_n;
        bit   acc;
        cmd_t c;

        reset = 1'b0;
        drive(1'b0, '0);
        res_ready = 1'b0;
        l3_cmd_valid = 1'b0;
        {l3_cmd_a, l3_cmd_b, l3_cmd_s, l3_cmd_cin, l3_cmd_h} = '0;
        l3_res_ready = 1'b0;
        model_reset();

        // Reset state
        assert_reset();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu", {alu_a, alu_b, alu_s, alu_cin, alu_h}, 0);
        check("rst_tag", res_tag, 0);
        release_reset();

        // Single op: 3 ^ 5 = 6
        res_ready = 1'b1;
        drive(1'b1, '{a: 4'd3, b: 4'd5, s: 3'd2, cin: 1'b1, h: 2'd1});
        step();
        cmd_valid = 1'b0;
        step();
        check("t2_alu_a", alu_a, 3);
        check("t2_early_valid", res_valid, 0);
        step();
        check("t2_valid", res_valid, 1);
        check("t2_o", res_o, 6);
        check("t2_cout", res_cout, 1);
        check("t2_tag", res_tag, 0);
        repeat (3) step();

        // Fill with consumer stalled
        assert_reset();
        release_reset();
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, '{a: 4'(i + 1), b: 4'd2, s: 3'(i), cin: 1'(i), h: 2'(i)});
            if (i == 5) check("fill_ready_6th", cmd_ready, 0);
            if (cmd_ready) acc_n++;
            step();
        end
        cmd_valid = 1'b0;
        check("fill_accepted", acc_n, 5);
        for (int i = 0; i < 4; i++) begin
            step();
            check("fill_hold_o", res_o, 3);
        end
        res_ready = 1'b1;
        repeat (30) step();

        // Ordering and tags under toggling backpressure
        assert_reset();
        release_reset();
        got_o.delete();
        got_tag.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, '{a: 4'(i), b: 4'd0, s: 3'd0, cin: 1'b0, h: 2'd0});
            acc = 1'b0;
            for (int w = 0; w < 50 && !acc; w++) begin
                res_ready = ~res_ready;
                acc = cmd_ready;
                step();
            end
            check("t4_push_accepted", acc, 1);
        end
        cmd_valid = 1'b0;
        for (int w = 0; w < 200 && got_o.size() < 6; w++) begin
            res_ready = ~res_ready;
            step();
        end
        check("t4_result_count", got_o.size(), 6);
        for (int i = 0; i < got_o.size(); i++) begin
            check("t4_order_o", got_o[i], 4'(i));
            check("t4_order_tag", got_tag[i], i % 4);
        end

        // Randomised traffic, with one reset in the middle
        assert_reset();
        release_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) begin
                assert_reset();
                release_reset();
            end
            c = rand_cmd();
            drive(($urandom % 2) == 1, c);
            res_ready = ($urandom % 4) != 0;
            step();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        repeat (30) step();
        check("rand_drained_busy", busy, 0);

        // RESULT_LAT=3: exact capture timing, stale stub output must not be captured
        assert_reset();
        release_reset();
        l3_res_ready = 1'b1;
        l3_cmd_valid = 1'b1;
        {l3_cmd_a, l3_cmd_b, l3_cmd_s, l3_cmd_cin, l3_cmd_h} = {4'd5, 4'd3, 3'd0, 1'b1, 2'd0};
        @(negedge clk);
        {l3_cmd_a, l3_cmd_b, l3_cmd_s, l3_cmd_cin, l3_cmd_h} = {4'd15, 4'd15, 3'd1, 1'b0, 2'd2};
        @(negedge clk);
        l3_cmd_valid = 1'b0;
        check("l3_issue1_a", l3_alu_a, 5);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("l3_op1_valid", l3_res_valid, k == 3);
        end
        check("l3_op1_o", l3_res_o, 6);
        check("l3_op1_cout", l3_res_cout, 1);
        check("l3_op1_tag", l3_res_tag, 0);
        @(negedge clk);
        check("l3_done_exit", l3_res_valid, 0);
        @(negedge clk);
        check("l3_issue2_a", l3_alu_a, 15);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("l3_op2_valid", l3_res_valid, k == 3);
        end
        check("l3_op2_o", l3_res_o, 0);
        check("l3_op2_cout", l3_res_cout, 0);
        check("l3_op2_tag", l3_res_tag, 1);
        repeat (3) @(negedge clk);

        // Reset while waiting on the ALU with two commands queued
        l3_res_ready = 1'b1;
        l3_cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            {l3_cmd_a, l3_cmd_b, l3_cmd_s, l3_cmd_cin, l3_cmd_h} = {4'(i + 7), 4'd1, 3'd0, 1'b1, 2'd0};
            @(negedge clk);
        end
        l3_cmd_valid = 1'b0;
        check("t6_busy_before", l3_busy, 1);
        check("t6_wait_valid", l3_res_valid, 0);
        assert_reset();
        check("t6_rst_ready", l3_cmd_ready, 1);
        check("t6_rst_busy", l3_busy, 0);
        check("t6_rst_valid", l3_res_valid, 0);
        check("t6_rst_alu", {l3_alu_a, l3_alu_b, l3_alu_s, l3_alu_cin, l3_alu_h}, 0);
        check("t6_rst_res", {l3_res_o, l3_res_cout, l3_res_tag}, 0);
        release_reset();
        l3_res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_no_reissue_valid", l3_res_valid, 0);
            check("t6_no_reissue_busy", l3_busy, 0);
            check("t6_no_reissue_alu", l3_alu_a, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
